unidad_busqueda: RTL and testbench

- Instruction fetch stage of the RV32I core, directly upstream of the immediate generator `valor_inmediato` and the register decode.
- Keeps the PC and issues one word request at a time to instruction memory. Latches the returned word into an instruction register.
- Presents `inst` plus a decoded 3-bit immediate format `tipo` to downstream logic through a valid/ready handshake.
- Handles redirects (`salto`) from execute, including discarding an in-flight response, and flags misaligned targets.

---
 rtl/rv32i_pkg.sv | 32 +++
 rtl/decodificador_tipo.sv | 21 ++
 rtl/unidad_busqueda.sv | 110 +++++++++++
 tb/tb_unidad_busqueda.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, immediate format codes and fetch FSM states.
// The tipo codes here are also consumed by valor_inmediato.
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] TIPO_I       = 3'b000;
    localparam logic [2:0] TIPO_S       = 3'b001;
    localparam logic [2:0] TIPO_B       = 3'b010;
    localparam logic [2:0] TIPO_U       = 3'b011;
    localparam logic [2:0] TIPO_J       = 3'b100;
    localparam logic [2:0] TIPO_NINGUNO = 3'b111;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        INACTIVO,
        PEDIR,
        ESPERAR,
        ENTREGAR,
        ERROR
    } estado_t;

endpackage

// File: rtl/decodificador_tipo.sv
// Maps an RV32I opcode to its immediate format code; purely combinational.
module decodificador_tipo
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] tipo
);

    always_comb begin
        tipo = TIPO_NINGUNO;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: tipo = TIPO_I;
            OP_STORE:                 tipo = TIPO_S;
            OP_BRANCH:                tipo = TIPO_B;
            OP_LUI, OP_AUIPC:         tipo = TIPO_U;
            OP_JAL:                   tipo = TIPO_J;
            default:                  tipo = TIPO_NINGUNO;
        endcase
    end

endmodule

// File: rtl/unidad_busqueda.sv
// RV32I instruction fetch stage: one outstanding memory request, instruction
// register with valid/ready handoff to decode, redirects and misalignment trap.
module unidad_busqueda #(
    parameter logic [31:0] PC_INICIAL = 32'h0000_0000,
    parameter logic [31:0] INST_NOP   = rv32i_pkg::INST_NOP
) (
    input  logic        clk,
    input  logic        nreset,
    output logic        mem_req,
    output logic [31:0] mem_dir,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_dato,
    input  logic        salto,
    input  logic [31:0] salto_destino,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [2:0]  tipo,
    output logic        inst_valido,
    input  logic        dec_listo,
    output logic        excepcion
);

    import rv32i_pkg::*;

    estado_t estado;
    logic    descartar;

    // Outputs are pure decodes of the state register, so they never glitch.
    assign mem_req     = (estado == PEDIR);
    assign mem_dir     = pc;
    assign inst_valido = (estado == ENTREGAR);

    decodificador_tipo u_decodificador_tipo (
        .opcode (inst[6:0]),
        .tipo   (tipo)
    );

    // A redirect outranks every other event; descartar marks a response that
    // is still owed by memory but belongs to the abandoned path.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            estado    <= INACTIVO;
            pc        <= PC_INICIAL;
            inst      <= INST_NOP;
            excepcion <= 1'b0;
            descartar <= 1'b0;
        end else if (salto && estado != ERROR) begin
            pc <= salto_destino;
            if (salto_destino[1:0] != 2'b00) begin
                estado    <= ERROR;
                excepcion <= 1'b1;
                descartar <= 1'b0;
            end else begin
                case (estado)
                    PEDIR: begin
                        if (mem_ack) begin
                            estado    <= ESPERAR;
                            descartar <= 1'b1;
                        end
                    end
                    ESPERAR: begin
                        descartar <= !mem_rvalid;
                        if (mem_rvalid) begin
                            estado <= PEDIR;
                        end
                    end
                    ENTREGAR: begin
                        inst   <= INST_NOP;
                        estado <= PEDIR;
                    end
                    default: begin
                        estado <= PEDIR;
                    end
                endcase
            end
        end else begin
            case (estado)
                INACTIVO: begin
                    estado <= PEDIR;
                end
                PEDIR: begin
                    if (mem_ack) begin
                        estado <= ESPERAR;
                    end
                end
                ESPERAR: begin
                    if (mem_rvalid) begin
                        if (descartar) begin
                            descartar <= 1'b0;
                            estado    <= PEDIR;
                        end else begin
                            inst   <= mem_dato;
                            estado <= ENTREGAR;
                        end
                    end
                end
                ENTREGAR: begin
                    if (dec_listo) begin
                        pc     <= pc + 32'd4;
                        estado <= PEDIR;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_busqueda.sv
// Self-checking bench for unidad_busqueda: directed scenarios followed by a
// randomized run checked against an address-level model of the fetch stream.
module tb_unidad_busqueda;

    logic        clk = 1'b0;
    logic        nreset;
    logic        mem_req;
    logic [31:0] mem_dir;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_dato;
    logic        salto;
    logic [31:0] salto_destino;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  tipo;
    logic        inst_valido;
    logic        dec_listo;
    logic        excepcion;

    int tests = 0;
    int fails = 0;

    unidad_busqueda dut (
        .clk           (clk),
        .nreset        (nreset),
        .mem_req       (mem_req),
        .mem_dir       (mem_dir),
        .mem_ack       (mem_ack),
        .mem_rvalid    (mem_rvalid),
        .mem_dato      (mem_dato),
        .salto         (salto),
        .salto_destino (salto_destino),
        .inst          (inst),
        .pc            (pc),
        .tipo          (tipo),
        .inst_valido   (inst_valido),
        .dec_listo     (dec_listo),
        .excepcion     (excepcion)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ack, input logic rv, input logic [31:0] dato,
                                 input logic listo, input logic sal, input logic [31:0] dest);
        mem_ack       = ack;
        mem_rvalid    = rv;
        mem_dato      = dato;
        dec_listo     = listo;
        salto         = sal;
        salto_destino = dest;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Immediate format straight from the opcode table of the ISA.
    function automatic logic [2:0] ref_tipo(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'h03 || op == 7'h13 || op == 7'h67) return 3'd0;
        if (op == 7'h23) return 3'd1;
        if (op == 7'h63) return 3'd2;
        if (op == 7'h37 || op == 7'h17) return 3'd3;
        if (op == 7'h6F) return 3'd4;
        return 3'd7;
    endfunction

    // Memory content: distinct word per address, cycling through all formats.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [6:0] opcs [10];
        logic [24:0] hi;
        opcs = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};
        hi = a[26:2] ^ 25'h0ABCDEF;
        return {hi, opcs[(a >> 2) % 10]};
    endfunction

    task automatic resetPulse();
        nreset = 1'b0;
        #2;
        nreset = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] out_addr;
        logic [31:0] dest;
        logic [31:0] w;
        logic        outstanding;
        logic        a_v, r_v, d_v, s_v;
        logic [31:0] dat;
        int          cnt;
        int          idle;

        nreset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("rst_req", mem_req, 0);
        checkOutput("rst_valido", inst_valido, 0);
        checkOutput("rst_exc", excepcion, 0);
        checkOutput("rst_inst", inst, 32'h13);
        checkOutput("rst_tipo", tipo, 0);
        checkOutput("rst_pc", pc, 0);
        nreset = 1'b1;

        // Plan 1: first fetch and delivery
        tick();
        checkOutput("p1_req", mem_req, 1);
        checkOutput("p1_dir", mem_dir, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        checkOutput("p1_wait_req", mem_req, 0);
        applyStimulus(0, 1, 32'h00500093, 1, 0, 0);
        tick();
        checkOutput("p1_valido", inst_valido, 1);
        checkOutput("p1_inst", inst, 32'h00500093);
        checkOutput("p1_tipo", tipo, 0);
        checkOutput("p1_pc", pc, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        tick();
        checkOutput("p1_next_req", mem_req, 1);
        checkOutput("p1_next_dir", mem_dir, 4);
        checkOutput("p1_next_valido", inst_valido, 0);

        // Plan 2: decode stall holds the instruction
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 1, 32'h00112223, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("p2_hold_inst", inst, 32'h00112223);
            checkOutput("p2_hold_pc", pc, 4);
            checkOutput("p2_hold_tipo", tipo, 3'b001);
            checkOutput("p2_hold_req", mem_req, 0);
            checkOutput("p2_hold_valido", inst_valido, 1);
            tick();
        end
        applyStimulus(0, 0, 0, 1, 0, 0);
        tick();
        checkOutput("p2_pc", pc, 8);
        checkOutput("p2_req", mem_req, 1);

        // Plan 3: redirect while waiting drops the response
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 32'h100);
        tick();
        checkOutput("p3_wait_req", mem_req, 0);
        applyStimulus(0, 1, 32'hDEADBEEF, 0, 0, 0);
        tick();
        checkOutput("p3_valido", inst_valido, 0);
        checkOutput("p3_req", mem_req, 1);
        checkOutput("p3_dir", mem_dir, 32'h100);

        // Plan 4: redirect beats dec_listo in the same cycle
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 1, 32'h0000006F, 0, 0, 0);
        tick();
        checkOutput("p4_tipo_j", tipo, 3'b100);
        checkOutput("p4_pc", pc, 32'h100);
        applyStimulus(0, 0, 0, 1, 1, 32'h200);
        tick();
        checkOutput("p4_flush_inst", inst, 32'h13);
        checkOutput("p4_flush_valido", inst_valido, 0);
        checkOutput("p4_dir", mem_dir, 32'h200);
        checkOutput("p4_not_old", pc == 32'h104, 0);

        // Redirect coinciding with ack: the acked word must be discarded
        applyStimulus(1, 0, 0, 0, 1, 32'h300);
        tick();
        checkOutput("pa_wait_req", mem_req, 0);
        checkOutput("pa_pc", pc, 32'h300);
        applyStimulus(0, 1, 32'h12345013, 0, 0, 0);
        tick();
        checkOutput("pa_valido", inst_valido, 0);
        checkOutput("pa_dir", mem_dir, 32'h300);
        checkOutput("pa_req", mem_req, 1);

        // Plan 5: misaligned target traps until reset
        applyStimulus(0, 0, 0, 0, 1, 32'h102);
        tick();
        checkOutput("p5_pc", pc, 32'h102);
        applyStimulus(1, 1, 32'h00000013, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            checkOutput("p5_exc", excepcion, 1);
            checkOutput("p5_req", mem_req, 0);
            checkOutput("p5_valido", inst_valido, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        nreset = 1'b0;
        #1;
        checkOutput("p5_rst_exc", excepcion, 0);
        checkOutput("p5_rst_dir", mem_dir, 0);
        nreset = 1'b1;
        tick();
        checkOutput("p5_restart_req", mem_req, 1);

        // Plan 6: reset while waiting, stale response after release
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        resetPulse();
        checkOutput("p6_rst_req", mem_req, 0);
        applyStimulus(0, 1, 32'hBADC0DE7, 0, 0, 0);
        tick();
        checkOutput("p6_req", mem_req, 1);
        checkOutput("p6_dir", mem_dir, 0);
        tick();
        checkOutput("p6_stale_valido", inst_valido, 0);
        checkOutput("p6_stale_inst", inst, 32'h13);
        checkOutput("p6_stale_req", mem_req, 1);

        // PC wrap-around
        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        tick();
        checkOutput("wrap_dir", mem_dir, 32'hFFFF_FFFC);
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 1, 32'h12345037, 0, 0, 0);
        tick();
        checkOutput("wrap_pc", pc, 32'hFFFF_FFFC);
        checkOutput("wrap_tipo", tipo, 3'b011);
        applyStimulus(0, 0, 0, 1, 0, 0);
        tick();
        checkOutput("wrap_next_dir", mem_dir, 0);
        checkOutput("wrap_next_req", mem_req, 1);

        // Redirect arriving while still idle after reset
        applyStimulus(0, 0, 0, 0, 1, 32'h40);
        resetPulse();
        tick();
        checkOutput("idle_salto_req", mem_req, 1);
        checkOutput("idle_salto_dir", mem_dir, 32'h40);

        // Randomized run against the fetch-stream model
        applyStimulus(0, 0, 0, 0, 0, 0);
        resetPulse();
        exp_pc      = 32'h0;
        outstanding = 1'b0;
        out_addr    = 32'h0;
        cnt         = 0;
        idle        = 0;
        for (int c = 0; c < 1500; c++) begin
            checkOutput("rnd_exc", excepcion, 0);
            if (mem_req) begin
                checkOutput("rnd_dir", mem_dir, exp_pc);
                checkOutput("rnd_single", outstanding, 0);
            end
            if (inst_valido) begin
                w = word_at(exp_pc);
                checkOutput("rnd_pc", pc, exp_pc);
                checkOutput("rnd_inst", inst, w);
                checkOutput("rnd_tipo", tipo, ref_tipo(w));
                checkOutput("rnd_excl", mem_req, 0);
            end

            a_v = 1'b0;
            r_v = 1'b0;
            dat = $urandom;
            if (outstanding) begin
                if (cnt == 0) begin
                    r_v         = 1'b1;
                    dat         = word_at(out_addr);
                    outstanding = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (mem_req && $urandom_range(0, 3) == 0) begin
                r_v = 1'b1;
            end
            if (mem_req && $urandom_range(0, 1) == 1) begin
                a_v         = 1'b1;
                outstanding = 1'b1;
                out_addr    = mem_dir;
                cnt         = $urandom_range(0, 2);
            end
            d_v = 1'($urandom_range(0, 1));
            s_v = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0) begin
                dest = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
            end else begin
                dest = 32'($urandom_range(0, 255)) << 2;
            end

            idle++;
            if (s_v) begin
                exp_pc = dest;
                idle   = 0;
            end else if (inst_valido && d_v) begin
                exp_pc = exp_pc + 32'd4;
                idle   = 0;
            end
            if (idle > 200) begin
                checkOutput("rnd_progress_timeout", idle, 0);
                break;
            end

            applyStimulus(a_v, r_v, dat, d_v, s_v, dest);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
